trace_scheduler: RTL

- Round-robin scheduler that shares the single plot-point write port of the LCM/VGA scope display between up to NCH waveform sources.
- Each source is a triangle/ramp-style generator presenting X/Y sample pairs.
- Per-channel enable and a global decimation ratio are applied.
- Forwards one registered (x, y, channel) point per handshake to the downstream plotter/framebuffer writer.

---
 rtl/trace_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/trace_scheduler.sv
// Round-robin scheduler sharing one registered plot-point port between NCH waveform sources.
// Latency: 1 cycle from source handshake to plot_valid; stalls hold the slot, discards never stall.
module trace_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 14,
    parameter int CHW = 2,
    parameter int DW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic [NCH-1:0]   ch_en,
    input  logic [DW-1:0]    decim,
    input  logic [NCH-1:0]   src_valid,
    input  logic [NCH*W-1:0] src_x,
    input  logic [NCH*W-1:0] src_y,
    output logic [NCH-1:0]   src_ready,
    output logic             plot_valid,
    input  logic             plot_ready,
    output logic [W-1:0]     plot_x,
    output logic [W-1:0]     plot_y,
    output logic [CHW-1:0]   plot_ch
);

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] discard;
    logic [NCH-1:0] gnt_oh;
    logic [CHW-1:0] last;
    logic [CHW-1:0] gnt_idx;
    logic [CHW:0]   cand;
    logic           gnt_vld;
    logic           slot_free;
    logic           active;
    logic [DW-1:0]  cnt [NCH];

    assign active    = rst_n & ~sync;
    assign slot_free = ~plot_valid | plot_ready;

    always_comb begin
        eligible = '0;
        discard  = '0;
        for (int c = 0; c < NCH; c++) begin
            eligible[c] = ch_en[c] & src_valid[c] & (cnt[c] == '0);
            discard[c]  = src_valid[c] & (~ch_en[c] | (cnt[c] != '0));
        end
    end

    // Search from the farthest candidate down to last+1 so the nearest eligible one wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (active && slot_free) begin
            for (int i = NCH; i >= 1; i--) begin
                cand = {1'b0, last} + (CHW+1)'(i);
                if (cand >= (CHW+1)'(NCH))
                    cand = cand - (CHW+1)'(NCH);
                if (eligible[cand[CHW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[CHW-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld)
            gnt_oh[gnt_idx] = 1'b1;
    end

    assign src_ready = active ? (discard | gnt_oh) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            plot_valid <= 1'b0;
            plot_x     <= '0;
            plot_y     <= '0;
            plot_ch    <= '0;
            last       <= CHW'(NCH-1);
        end else if (sync) begin
            plot_valid <= 1'b0;
            last       <= CHW'(NCH-1);
        end else if (gnt_vld) begin
            plot_valid <= 1'b1;
            plot_x     <= src_x[gnt_idx*W +: W];
            plot_y     <= src_y[gnt_idx*W +: W];
            plot_ch    <= gnt_idx;
            last       <= gnt_idx;
        end else if (plot_ready) begin
            plot_valid <= 1'b0;
        end
    end

    // Countdown reloads from decim only at zero, so a decim change never truncates a running count.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n || sync || !ch_en[c])
                cnt[c] <= '0;
            else if (src_ready[c])
                cnt[c] <= (cnt[c] == '0) ? decim : cnt[c] - DW'(1);
        end
    end

endmodule
